// File: rtl/johnson_pkg.sv
// Shared constants, types and the phase-to-code mapping for the Johnson counter monitor.
package johnson_pkg;

    localparam int unsigned JOHNSON_BITS   = 8;
    localparam int unsigned JOHNSON_PHASES = 16;
    localparam int unsigned PHASE_W        = 4;

    localparam logic [7:0] OFF_CTRL     = 8'h00;
    localparam logic [7:0] OFF_STATUS   = 8'h04;
    localparam logic [7:0] OFF_WRAP_CNT = 8'h08;
    localparam logic [7:0] OFF_ERR_CNT  = 8'h0C;
    localparam logic [7:0] OFF_LAST_BAD = 8'h10;

    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT = 1;
    localparam int unsigned CTRL_CLR_BIT    = 2;

    localparam int unsigned STATUS_LEGAL_BIT  = 0;
    localparam int unsigned STATUS_STICKY_BIT = 1;
    localparam int unsigned STATUS_PHASE_LSB  = 4;

    typedef struct packed {
        logic                    vld;
        logic [JOHNSON_BITS-1:0] code;
    } sample_t;

    typedef struct packed {
        logic                    vld;
        logic                    legal;
        logic [PHASE_W-1:0]      phase;
        logic [JOHNSON_BITS-1:0] code;
    } class_t;

    // Phases 0..7 fill ones from the LSB; phases 8..15 shift zeros in from the LSB.
    function automatic logic [JOHNSON_BITS-1:0] johnson_code(input logic [PHASE_W-1:0] phase);
        logic [JOHNSON_BITS-1:0] ones;
        logic [JOHNSON_BITS-1:0] shifted;
        ones    = '1;
        shifted = ones << phase[PHASE_W-2:0];
        return phase[PHASE_W-1] ? shifted : ~shifted;
    endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational classifier: maps an 8-bit Johnson code to {legal, phase}.
module johnson_decode
    import johnson_pkg::*;
(
    input  logic [JOHNSON_BITS-1:0] code_i,
    output logic                    legal_o,
    output logic [PHASE_W-1:0]      phase_o
);

    always_comb begin
        legal_o = 1'b0;
        phase_o = '0;
        for (int unsigned p = 0; p < JOHNSON_PHASES; p++) begin
            if (code_i == johnson_code(PHASE_W'(p))) begin
                legal_o = 1'b1;
                phase_o = PHASE_W'(p);
            end
        end
    end

endmodule

// File: rtl/johnson_monitor.sv
// Johnson counter sequence monitor with a Wishbone register slave and error interrupt.
module johnson_monitor
    import johnson_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0100
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_we_i,
    input  logic [3:0]              wbs_sel_i,
    input  logic [31:0]             wbs_adr_i,
    input  logic [31:0]             wbs_dat_i,
    output logic                    wbs_ack_o,
    output logic [31:0]             wbs_dat_o,
    input  logic [JOHNSON_BITS-1:0] count_i,
    output logic                    irq_o
);

    logic                    en_q, en_d;
    logic                    irq_en_q, irq_en_d;
    sample_t                 s1_q, s1_d;
    class_t                  s2_q, s2_d;
    logic                    prev_vld_q, prev_vld_d;
    logic [PHASE_W-1:0]      prev_phase_q, prev_phase_d;
    logic                    cur_legal_q, cur_legal_d;
    logic [PHASE_W-1:0]      cur_phase_q, cur_phase_d;
    logic                    sticky_q, sticky_d;
    logic [31:0]             wrap_cnt_q, wrap_cnt_d;
    logic [31:0]             err_cnt_q, err_cnt_d;
    logic [JOHNSON_BITS-1:0] last_bad_q, last_bad_d;
    logic                    irq_q, irq_d;
    logic                    ack_q, ack_d;
    logic [31:0]             dat_q, dat_d;

    logic                    dec_legal;
    logic [PHASE_W-1:0]      dec_phase;

    johnson_decode u_decode (
        .code_i  (s1_q.code),
        .legal_o (dec_legal),
        .phase_o (dec_phase)
    );

    // A strobe is taken only while no ack is outstanding, so acks never run back to back.
    logic       wb_valid, wb_take, ctrl_wr, clr;
    logic [7:0] wb_off;

    assign wb_valid = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign wb_take  = wb_valid & ~ack_q;
    assign wb_off   = wbs_adr_i[7:0];
    assign ctrl_wr  = wb_take & wbs_we_i & wbs_sel_i[0] & (wb_off == OFF_CTRL);
    assign clr      = ctrl_wr & wbs_dat_i[CTRL_CLR_BIT];

    logic unused_wb_bits;
    assign unused_wb_bits = ^{wbs_dat_i[31:3], wbs_sel_i[3:1]};

    logic               proc, step_ok, step_err, err_evt, wrap_evt;
    logic [PHASE_W-1:0] prev_phase_inc;

    assign prev_phase_inc = prev_phase_q + PHASE_W'(1);
    assign proc     = en_q & s2_q.vld;
    assign step_ok  = (s2_q.phase == prev_phase_q) || (s2_q.phase == prev_phase_inc);
    assign step_err = proc & s2_q.legal & prev_vld_q & ~step_ok;
    assign err_evt  = (proc & ~s2_q.legal) | step_err;
    assign wrap_evt = proc & s2_q.legal & prev_vld_q
                    & (prev_phase_q == PHASE_W'(JOHNSON_PHASES - 1)) & (s2_q.phase == '0);

    always_comb begin
        en_d         = en_q;
        irq_en_d     = irq_en_q;
        s1_d         = s1_q;
        s2_d         = s2_q;
        prev_vld_d   = prev_vld_q;
        prev_phase_d = prev_phase_q;
        cur_legal_d  = cur_legal_q;
        cur_phase_d  = cur_phase_q;
        sticky_d     = sticky_q;
        wrap_cnt_d   = wrap_cnt_q;
        err_cnt_d    = err_cnt_q;
        last_bad_d   = last_bad_q;

        if (ctrl_wr) begin
            en_d     = wbs_dat_i[CTRL_EN_BIT];
            irq_en_d = wbs_dat_i[CTRL_IRQ_EN_BIT];
        end

        if (en_q) begin
            s1_d.vld   = 1'b1;
            s1_d.code  = count_i;
            s2_d.vld   = s1_q.vld;
            s2_d.legal = dec_legal;
            s2_d.phase = dec_phase;
            s2_d.code  = s1_q.code;
        end

        // An illegal sample drops the reference phase so the next legal one starts fresh.
        if (proc) begin
            cur_legal_d = s2_q.legal;
            prev_vld_d  = s2_q.legal;
            if (s2_q.legal) begin
                cur_phase_d  = s2_q.phase;
                prev_phase_d = s2_q.phase;
            end
        end

        if (wrap_evt) begin
            wrap_cnt_d = wrap_cnt_q + 32'd1;
        end

        if (err_evt) begin
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + 32'd1;
            end
            sticky_d   = 1'b1;
            last_bad_d = s2_q.code;
        end

        if (clr) begin
            wrap_cnt_d = '0;
            err_cnt_d  = '0;
            last_bad_d = '0;
            sticky_d   = 1'b0;
            prev_vld_d = 1'b0;
        end
    end

    logic [31:0] rdata;

    always_comb begin
        rdata = '0;
        case (wb_off)
            OFF_CTRL: begin
                rdata[CTRL_EN_BIT]     = en_q;
                rdata[CTRL_IRQ_EN_BIT] = irq_en_q;
            end
            OFF_STATUS: begin
                rdata[STATUS_LEGAL_BIT]  = cur_legal_q;
                rdata[STATUS_STICKY_BIT] = sticky_q;
                rdata[STATUS_PHASE_LSB +: PHASE_W] = cur_phase_q;
            end
            OFF_WRAP_CNT: rdata = wrap_cnt_q;
            OFF_ERR_CNT:  rdata = err_cnt_q;
            OFF_LAST_BAD: rdata[JOHNSON_BITS-1:0] = last_bad_q;
            default:      rdata = '0;
        endcase
    end

    always_comb begin
        ack_d = wb_take;
        dat_d = (wb_take & ~wbs_we_i) ? rdata : '0;
        irq_d = sticky_q & irq_en_q;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            en_q         <= 1'b1;
            irq_en_q     <= 1'b0;
            s1_q         <= '0;
            s2_q         <= '0;
            prev_vld_q   <= 1'b0;
            prev_phase_q <= '0;
            cur_legal_q  <= 1'b0;
            cur_phase_q  <= '0;
            sticky_q     <= 1'b0;
            wrap_cnt_q   <= '0;
            err_cnt_q    <= '0;
            last_bad_q   <= '0;
            irq_q        <= 1'b0;
            ack_q        <= 1'b0;
            dat_q        <= '0;
        end else begin
            en_q         <= en_d;
            irq_en_q     <= irq_en_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            prev_vld_q   <= prev_vld_d;
            prev_phase_q <= prev_phase_d;
            cur_legal_q  <= cur_legal_d;
            cur_phase_q  <= cur_phase_d;
            sticky_q     <= sticky_d;
            wrap_cnt_q   <= wrap_cnt_d;
            err_cnt_q    <= err_cnt_d;
            last_bad_q   <= last_bad_d;
            irq_q        <= irq_d;
            ack_q        <= ack_d;
            dat_q        <= dat_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_johnson_monitor.sv
// Directed self-checking bench for johnson_monitor.
module tb_johnson_monitor;

    localparam logic [31:0] BASE = 32'h3000_0100;
    localparam logic [7:0]  R_CTRL = 8'h00, R_STATUS = 8'h04, R_WRAP = 8'h08,
                            R_ERR = 8'h0C, R_LAST = 8'h10, R_NONE = 8'h14;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] rdat;
    logic [7:0]  count;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  seq [16];
    logic [31:0] rd;
    logic        seen;

    always #5 clk = ~clk;

    johnson_monitor #(.BASE_ADDR(BASE)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_ack_o (ack),
        .wbs_dat_o (rdat),
        .count_i   (count),
        .irq_o     (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb_access(input logic is_wr, input logic [7:0] off, input logic [31:0] data,
                             input logic [3:0] bsel, output logic [31:0] rvalue);
        logic got_ack;
        got_ack = 1'b0;
        rvalue  = '0;
        cyc = 1'b1; stb = 1'b1; we = is_wr; sel = bsel;
        adr = {BASE[31:8], off}; wdat = data;
        for (int i = 0; i < 8 && !got_ack; i++) begin
            @(negedge clk);
            if (ack) begin
                got_ack = 1'b1;
                rvalue  = rdat;
            end else begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; wdat = '0;
        check(is_wr ? "wr_ack" : "rd_ack", got_ack, 1'b1);
    endtask

    task automatic wb_write(input logic [7:0] off, input logic [31:0] data, input logic [3:0] bsel);
        logic [31:0] dummy;
        wb_access(1'b1, off, data, bsel, dummy);
    endtask

    task automatic wb_read(input logic [7:0] off, output logic [31:0] data);
        wb_access(1'b0, off, '0, 4'hF, data);
    endtask

    task automatic run_sequence();
        for (int i = 1; i <= 16; i++) begin
            count = seq[i % 16];
            tick(1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        seq = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'hF;
        adr = '0; wdat = '0; count = 8'h00;

        // Reset state
        tick(3);
        @(negedge clk);
        check("rst_ack", ack, 1'b0);
        check("rst_dat", rdat, 32'h0);
        check("rst_irq", irq, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        wb_read(R_CTRL, rd);   check("rst_ctrl", rd, 32'h1);
        wb_read(R_WRAP, rd);   check("rst_wrap", rd, 32'h0);
        wb_read(R_ERR, rd);    check("rst_err", rd, 32'h0);
        wb_read(R_LAST, rd);   check("rst_last", rd, 32'h0);
        tick(4);
        wb_read(R_STATUS, rd); check("idle_status", rd, 32'h01);

        // Full legal revolution ending in a wrap
        run_sequence();
        tick(4);
        wb_read(R_WRAP, rd);   check("seq_wrap", rd, 32'h1);
        wb_read(R_ERR, rd);    check("seq_err", rd, 32'h0);
        wb_read(R_STATUS, rd); check("seq_status", rd, 32'h01);

        // Illegal code with interrupt enabled
        wb_write(R_CTRL, 32'h3, 4'hF);
        count = 8'h05;
        tick(1);
        count = 8'h00;
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge clk);
            if (irq) seen = 1'b1;
        end
        check("irq_rise", seen, 1'b1);
        tick(1);
        wb_read(R_ERR, rd);    check("ill_err", rd, 32'h1);
        wb_read(R_LAST, rd);   check("ill_last", rd, 32'h05);
        wb_read(R_STATUS, rd); check("ill_status", rd, 32'h03);

        // Clear, then a skipped phase followed by a held phase
        wb_write(R_CTRL, 32'h5, 4'hF);
        wb_read(R_ERR, rd);    check("clr_err", rd, 32'h0);
        wb_read(R_CTRL, rd);   check("clr_ctrl", rd, 32'h1);
        count = 8'h01; tick(1);
        count = 8'h03; tick(1);
        count = 8'h0F; tick(4);
        tick(3);
        wb_read(R_ERR, rd);    check("step_err", rd, 32'h1);
        wb_read(R_LAST, rd);   check("step_last", rd, 32'h0F);
        wb_read(R_STATUS, rd); check("step_status", rd, 32'h43);

        // Clear lands on the same edge as an illegal sample
        count = 8'h05; tick(1);
        count = 8'h0F; tick(1);
        wb_write(R_CTRL, 32'h4, 4'hF);
        wb_read(R_ERR, rd);    check("race_err", rd, 32'h0);
        wb_read(R_LAST, rd);   check("race_last", rd, 32'h0);
        wb_read(R_WRAP, rd);   check("race_wrap", rd, 32'h0);
        wb_read(R_STATUS, rd); check("race_sticky", rd[1], 1'b0);
        wb_read(R_CTRL, rd);   check("race_ctrl", rd, 32'h0);

        // Build nonzero counters, then freeze and feed random codes
        wb_write(R_CTRL, 32'h1, 4'hF);
        tick(3);
        count = 8'h05; tick(1);
        count = 8'h00; tick(3);
        run_sequence();
        tick(4);
        wb_write(R_CTRL, 32'h0, 4'hF);
        for (int i = 0; i < 20; i++) begin
            count = 8'($urandom_range(0, 255));
            tick(1);
        end
        tick(3);
        wb_read(R_WRAP, rd);   check("hold_wrap", rd, 32'h1);
        wb_read(R_ERR, rd);    check("hold_err", rd, 32'h1);
        wb_read(R_LAST, rd);   check("hold_last", rd, 32'h05);

        // Byte-select, read-only and unmapped accesses
        wb_write(R_CTRL, 32'h3, 4'hE);
        wb_read(R_CTRL, rd);   check("sel0_ctrl", rd, 32'h0);
        wb_write(R_WRAP, 32'hFFFF_FFFF, 4'hF);
        wb_read(R_WRAP, rd);   check("ro_wrap", rd, 32'h1);
        wb_read(R_NONE, rd);   check("unmapped_rd", rd, 32'h0);
        @(negedge clk);
        check("ack_one_cycle", ack, 1'b0);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0200;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ack) seen = 1'b1;
        end
        check("other_base", seen, 1'b0);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;

        // Reset mid-stream with a read pending
        count = 8'h00;
        wb_write(R_CTRL, 32'h3, 4'hF);
        tick(3);
        @(negedge clk);
        check("pre_rst_irq", irq, 1'b1);
        @(posedge clk); #1;
        count = 8'h01; tick(1);
        count = 8'h03; tick(1);
        rst = 1'b1; count = 8'h00;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = {BASE[31:8], R_STATUS};
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_drop_ack", ack, 1'b0);
        check("rst_irq_low", irq, 1'b0);
        @(negedge clk);
        check("retry_ack", ack, 1'b1);
        check("retry_status", rdat, 32'h0);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        wb_read(R_CTRL, rd);   check("mid_rst_ctrl", rd, 32'h1);
        wb_read(R_WRAP, rd);   check("mid_rst_wrap", rd, 32'h0);
        wb_read(R_ERR, rd);    check("mid_rst_err", rd, 32'h0);
        wb_read(R_LAST, rd);   check("mid_rst_last", rd, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
